divider_control_unit: RTL and testbench

//  Sequencer FSM for the radix-2 SRT carry-save divider datapath. Accepts a start request and

---
 rtl/div_ctrl_pkg.sv | 54 +++++
 rtl/div_step_counter.sv | 34 +++
 rtl/divider_control_unit.sv | 171 +++++++++++++++++
 tb/tb_divider_control_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
//   Shared types for the radix-2 SRT carry-save divider controller:
//   the sequencer state encoding, the packed datapath control word and the
//   named values of every datapath mux select.
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NEG,
    ITER,
    RESOLVE,
    CORRECT,
    SCALE,
    DONE
  } state_t;

  // Left carry-propagate adder input selection
  localparam logic [1:0] LADD_SUM_CARRY     = 2'b00;  // resolve remainder
  localparam logic [1:0] LADD_NOT_DIVISOR   = 2'b01;  // ~divisor + 0, completed by leftAddMode
  localparam logic [1:0] LADD_REM_PLUS_DIV  = 2'b10;  // remainder + divisor
  localparam logic [1:0] LADD_REM_MINUS_DIV = 2'b11;  // remainder - divisor

  // Right carry-propagate adder input selection
  localparam logic [1:0] RADD_QPOS_QNEG = 2'b00;      // Qpos + ~Qneg
  localparam logic [1:0] RADD_Q_CORR    = 2'b01;      // quotient + correction bit

  // Upper sum register source
  localparam logic SUMH_DIVIDEND = 1'b0;
  localparam logic SUMH_SHIFT    = 1'b1;

  // Quotient correction bit
  localparam logic QCORR_MINUS1 = 1'b0;
  localparam logic QCORR_PLUS1  = 1'b1;

  typedef struct packed {
    logic       divisor_en;
    logic       notDivisor_en;
    logic       save_reminder;
    logic       sumHMux_sel;
    logic       sum_en;
    logic       carry_en;
    logic       carry_clr;
    logic [1:0] leftAddMux_sel;
    logic [1:0] rightAddMux_sel;
    logic       QCorrectBitMux_sel;
    logic       leftAddMode;
    logic       rightAddMode;
    logic       reminder_en;
    logic       reminder_rShift;
    logic       quotient_en;
  } div_ctrl_t;

endpackage

// File: rtl/div_step_counter.sv
// div_step_counter
//   SRT step counter. Cleared while clr is high, increments while en is high.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     clr        synchronous clear (takes priority over en)
//     en         count enable
//     lastStep   high while the count equals PARALLELISM (final SRT step)
module div_step_counter #(
  parameter int PARALLELISM = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic lastStep
);

  localparam int CW = $clog2(PARALLELISM + 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign lastStep = (count == CW'(PARALLELISM));

endmodule

// File: rtl/divider_control_unit.sv
// divider_control_unit
//   Sequencer for the radix-2 SRT carry-save divider datapath:
//   LOAD -> NEG -> ITER x (PARALLELISM+1) -> RESOLVE -> [CORRECT] -> [SCALE] -> DONE.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     start           request, accepted only in IDLE
//     usigned_n       0 = unsigned, 1 = signed (latched on accepted start)
//     dividend_sign   dividend MSB (latched on accepted start)
//     divisor_sign    divisor MSB (latched on accepted start)
//     rem_sign        remainder MSB from the datapath
//     rem_zero        remainder == 0 from the datapath
//     busy            high in every state except IDLE
//     done            one-cycle pulse, results valid
//     ctrl            packed datapath control word (div_ctrl_t)
//   Build option DIV_CTRL_DIV0_DETECT_EN adds:
//     divisor_zero    divisor == 0 (latched on accepted start)
//     div_by_zero     flagged with done, held until the next accepted start
module divider_control_unit
  import div_ctrl_pkg::*;
#(
  parameter int PARALLELISM = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      usigned_n,
  input  logic      dividend_sign,
  input  logic      divisor_sign,
  input  logic      rem_sign,
  input  logic      rem_zero,
  output logic      busy,
  output logic      done,
  output div_ctrl_t ctrl
`ifdef DIV_CTRL_DIV0_DETECT_EN
  ,
  input  logic      divisor_zero,
  output logic      div_by_zero
`endif
);

  state_t state;
  logic   usignedN;
  logic   dividendSign;
  logic   divisorSign;
  logic   corrSub;     // 1: rem - divisor with quotient +1; 0: rem + divisor with quotient -1
  logic   lastStep;
  logic   needCorr;
  state_t afterCorr;

`ifdef DIV_CTRL_DIV0_DETECT_EN
  logic   divisorZero;
`endif

  div_step_counter #(
    .PARALLELISM(PARALLELISM)
  ) stepCounter (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ITER),
    .en      (state == ITER),
    .lastStep(lastStep)
  );

  // Remainder flags are consulted only when leaving RESOLVE; a remainder whose
  // sign disagrees with the dividend (and is nonzero) needs one fix-up step.
  assign needCorr  = !rem_zero && (rem_sign != dividendSign);
  // Signed operands skip SCALE; unsigned ones were pre-scaled by 2.
  assign afterCorr = usignedN ? DONE : SCALE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      usignedN     <= 1'b0;
      dividendSign <= 1'b0;
      divisorSign  <= 1'b0;
      corrSub      <= 1'b0;
`ifdef DIV_CTRL_DIV0_DETECT_EN
      divisorZero  <= 1'b0;
      div_by_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            usignedN     <= usigned_n;
            dividendSign <= dividend_sign;
            divisorSign  <= divisor_sign;
`ifdef DIV_CTRL_DIV0_DETECT_EN
            divisorZero  <= divisor_zero;
            div_by_zero  <= 1'b0;
`endif
          end
        end
        LOAD: begin
`ifdef DIV_CTRL_DIV0_DETECT_EN
          if (divisorZero) begin
            state       <= DONE;
            div_by_zero <= 1'b1;
          end else begin
            state <= NEG;
          end
`else
          state <= NEG;
`endif
        end
        NEG:     state <= ITER;
        ITER:    if (lastStep) state <= RESOLVE;
        RESOLVE: begin
          if (needCorr) begin
            state   <= CORRECT;
            corrSub <= (rem_sign == divisorSign);
          end else begin
            state <= afterCorr;
          end
        end
        CORRECT: state <= afterCorr;
        SCALE:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    ctrl = '0;
    case (state)
      LOAD: begin
        ctrl.divisor_en  = 1'b1;
        ctrl.sum_en      = 1'b1;
        ctrl.sumHMux_sel = SUMH_DIVIDEND;
        ctrl.carry_clr   = 1'b1;
      end
      NEG: begin
        ctrl.leftAddMux_sel = LADD_NOT_DIVISOR;
        ctrl.leftAddMode    = 1'b1;
        ctrl.notDivisor_en  = 1'b1;
      end
      ITER: begin
        ctrl.sum_en        = 1'b1;
        ctrl.carry_en      = 1'b1;
        ctrl.sumHMux_sel   = SUMH_SHIFT;
        ctrl.save_reminder = lastStep;
      end
      RESOLVE: begin
        ctrl.leftAddMux_sel  = LADD_SUM_CARRY;
        ctrl.leftAddMode     = 1'b0;
        ctrl.reminder_en     = 1'b1;
        ctrl.rightAddMux_sel = RADD_QPOS_QNEG;
        ctrl.rightAddMode    = 1'b1;
        ctrl.quotient_en     = 1'b1;
      end
      CORRECT: begin
        ctrl.leftAddMux_sel     = corrSub ? LADD_REM_MINUS_DIV : LADD_REM_PLUS_DIV;
        ctrl.QCorrectBitMux_sel = corrSub ? QCORR_PLUS1 : QCORR_MINUS1;
        ctrl.reminder_en        = 1'b1;
        ctrl.rightAddMux_sel    = RADD_Q_CORR;
        ctrl.quotient_en        = 1'b1;
      end
      SCALE: begin
        ctrl.reminder_rShift = 1'b1;
        ctrl.reminder_en     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_divider_control_unit.sv
module tb_divider_control_unit;
  import div_ctrl_pkg::*;

  localparam int P = 32;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      start = 1'b0;
  logic      usigned_n = 1'b0;
  logic      dividend_sign = 1'b0;
  logic      divisor_sign = 1'b0;
  logic      rem_sign = 1'b0;
  logic      rem_zero = 1'b0;
  logic      busy;
  logic      done;
  div_ctrl_t ctrl;
`ifdef DIV_CTRL_DIV0_DETECT_EN
  logic      divisor_zero = 1'b0;
  logic      div_by_zero;
  logic      expDbz = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  divider_control_unit #(
    .PARALLELISM(P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .usigned_n    (usigned_n),
    .dividend_sign(dividend_sign),
    .divisor_sign (divisor_sign),
    .rem_sign     (rem_sign),
    .rem_zero     (rem_zero),
    .busy         (busy),
    .done         (done),
    .ctrl         (ctrl)
`ifdef DIV_CTRL_DIV0_DETECT_EN
    ,
    .divisor_zero (divisor_zero),
    .div_by_zero  (div_by_zero)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control word for cycle k after the accepting edge, derived from
  // the operation timeline: LOAD, NEG, P+1 steps, RESOLVE, optional fix-up and
  // scaling, then DONE with an all-zero word.
  function automatic div_ctrl_t expCtrl(int k, int lat, bit corr, bit sub, bit scale);
    div_ctrl_t c;
    c = '0;
    if (k == lat) return c;
    if (k == 1) begin
      c.divisor_en = 1'b1; c.sum_en = 1'b1; c.sumHMux_sel = 1'b0; c.carry_clr = 1'b1;
    end else if (k == 2) begin
      c.leftAddMux_sel = 2'b01; c.leftAddMode = 1'b1; c.notDivisor_en = 1'b1;
    end else if (k >= 3 && k <= P + 3) begin
      c.sum_en = 1'b1; c.carry_en = 1'b1; c.sumHMux_sel = 1'b1;
      c.save_reminder = (k == P + 3);
    end else if (k == P + 4) begin
      c.leftAddMux_sel = 2'b00; c.leftAddMode = 1'b0; c.reminder_en = 1'b1;
      c.rightAddMux_sel = 2'b00; c.rightAddMode = 1'b1; c.quotient_en = 1'b1;
    end else if (corr && k == P + 5) begin
      c.leftAddMux_sel = sub ? 2'b11 : 2'b10;
      c.QCorrectBitMux_sel = sub ? 1'b1 : 1'b0;
      c.reminder_en = 1'b1; c.rightAddMux_sel = 2'b01; c.quotient_en = 1'b1;
    end else if (scale) begin
      c.reminder_rShift = 1'b1; c.reminder_en = 1'b1;
    end
    return c;
  endfunction

  // Issue one operation from IDLE (called at a falling edge) and check every
  // cycle until the controller is back in IDLE. hold keeps start high the whole
  // time; scramble toggles start and the latched inputs while busy.
  task automatic runOp(input bit usn, input bit ds, input bit vs, input bit rs,
                       input bit rz, input bit dz, input bit hold, input bit scramble);
    bit corr, sub, scale;
    int lat;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_ctrl", 32'(ctrl), 32'd0);
`ifdef DIV_CTRL_DIV0_DETECT_EN
    chk("idle_dbz", 32'(div_by_zero), 32'(expDbz));
    divisor_zero = dz;
`endif
    usigned_n = usn; dividend_sign = ds; divisor_sign = vs;
    rem_sign = rs; rem_zero = rz;
    start = 1'b1;
    corr  = !rz && (rs != ds);
    sub   = (rs == vs);
    scale = !usn;
    lat   = P + 5 + int'(corr) + int'(scale);
    if (dz) lat = 2;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!hold) start = scramble ? 1'($urandom) : 1'b0;
      if (scramble) begin
        usigned_n = 1'($urandom); dividend_sign = 1'($urandom); divisor_sign = 1'($urandom);
`ifdef DIV_CTRL_DIV0_DETECT_EN
        divisor_zero = 1'($urandom);
`endif
      end
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(k == lat));
      chk($sformatf("ctrl_k%0d", k), 32'(ctrl), 32'(expCtrl(k, lat, corr, sub, scale)));
`ifdef DIV_CTRL_DIV0_DETECT_EN
      chk("dbz", 32'(div_by_zero), (k == lat) ? 32'(dz) : 32'd0);
`endif
    end
    @(negedge clk);
`ifdef DIV_CTRL_DIV0_DETECT_EN
    expDbz = dz;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Abort during ITER with the step count at 10, then a normal operation
    usigned_n = 1'b1; start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_abort_ctrl", 32'(ctrl), 32'(expCtrl(13, P + 5, 1'b0, 1'b0, 1'b0)));
    rst = 1'b1;
    #1;
    chk("abort_ctrl", 32'(ctrl), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef DIV_CTRL_DIV0_DETECT_EN
    expDbz = 1'b0;
`endif
    @(negedge clk);
    runOp(1, 0, 0, 0, 0, 0, 0, 0);

    // Signed, no correction
    runOp(1, 0, 0, 0, 0, 0, 0, 0);
    // Signed, correction by adding the divisor
    runOp(1, 0, 0, 1, 0, 0, 0, 0);
    // Signed, correction by subtracting the divisor
    runOp(1, 1, 0, 0, 0, 0, 0, 0);
    // Unsigned, zero remainder: scaling only
    runOp(0, 0, 0, 1, 1, 0, 0, 0);
    // Unsigned with correction and scaling
    runOp(0, 0, 1, 1, 0, 0, 0, 0);
    // start held through DONE, then the follow-up request
    runOp(1, 0, 0, 0, 0, 0, 1, 0);
    runOp(0, 1, 1, 0, 0, 0, 0, 0);
`ifdef DIV_CTRL_DIV0_DETECT_EN
    runOp(1, 0, 0, 0, 0, 1, 0, 0);
    runOp(1, 0, 0, 0, 0, 0, 0, 0);
`endif

    repeat (25) begin
      bit dz;
      dz = 1'b0;
`ifdef DIV_CTRL_DIV0_DETECT_EN
      dz = ($urandom_range(0, 4) == 0);
`endif
      runOp(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), dz, 1'b0, 1'b1);
      start = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
